// File: rtl/modulo_updown_counter.sv
// Modulo-MODULUS up/down counter with clear, clamped parallel load and a combinational terminal-count flag.
// Define MODULO_COUNTER_SATURATE_EN to hold at the range ends instead of wrapping.
module modulo_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             count,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // The boundary compare comes before the add, so a full 2**WIDTH range never relies on overflow.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == MAXV) begin
`ifdef MODULO_COUNTER_SATURATE_EN
      r = MAXV;
`else
      r = '0;
`endif
    end else begin
      r = v + WIDTH'(1);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == '0) begin
`ifdef MODULO_COUNTER_SATURATE_EN
      r = '0;
`else
      r = MAXV;
`endif
    end else begin
      r = v - WIDTH'(1);
    end
    return r;
  endfunction

  logic [WIDTH-1:0] q_nxt;
  logic             at_end;

  always_comb begin
    at_end = up ? (q == MAXV) : (q == '0);
    tc     = count & ~clear & ~load & at_end;
  end

  always_comb begin
    q_nxt = q;
    if (clear) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = clamp_load(d);
    end else if (count) begin
      q_nxt = up ? step_up(q) : step_down(q);
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: doc/modulo_updown_counter.md
MODULO_UPDOWN_COUNTER -- requirements
Module: modulo_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of d and q.
REQ-002 Parameter MODULUS, default 16, SHALL set the count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 Port clock, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset (asserted at 0).
REQ-005 Port clear, input, 1 bit, SHALL be the synchronous clear request.
REQ-006 Port load, input, 1 bit, SHALL be the synchronous parallel-load request.
REQ-007 Port d, input, WIDTH bits, SHALL be the value to load.
REQ-008 Port count, input, 1 bit, SHALL be the count enable.
REQ-009 Port up, input, 1 bit, SHALL select direction: 1 increment, 0 decrement.
REQ-010 Port q, output, WIDTH bits, SHALL be the registered count value.
REQ-011 Port tc, output, 1 bit, SHALL be the combinational terminal-count flag.

Function
REQ-012 Priority per rising edge SHALL be clear > load > count > hold.
REQ-013 clear=1 SHALL set q to 0 on the next edge.
REQ-014 load=1 with clear=0 SHALL set q to d on the next edge when d <= MODULUS-1, and to MODULUS-1 otherwise.
REQ-015 count=1 with clear=0, load=0 and up=1 SHALL set q to q+1, and to 0 when q = MODULUS-1 (wrap).
REQ-016 count=1 with clear=0, load=0 and up=0 SHALL set q to q-1, and to MODULUS-1 when q = 0 (wrap).
REQ-017 count=0 with clear=0 and load=0 SHALL hold q.
REQ-018 tc SHALL be 1 when count=1, clear=0, load=0, and either (up=1 and q = MODULUS-1) or (up=0 and q = 0); otherwise tc SHALL be 0.
REQ-019 tc SHALL have zero-cycle latency from its inputs, and q SHALL have one-cycle latency from its inputs.
REQ-020 Arithmetic SHALL be performed at WIDTH bits with no intermediate overflow when MODULUS = 2**WIDTH.
REQ-021 A direction change on up SHALL take effect on the same edge, with no idle cycle.
REQ-022 Register q SHALL never hold a value above MODULUS-1 under any input sequence.

Reset
REQ-023 reset=0 SHALL force q to 0 immediately, independent of clock.
REQ-024 While reset=0, q SHALL remain 0, and tc SHALL be 0 whenever count=0.
REQ-025 On the first rising edge after reset returns to 1, the module SHALL apply REQ-012 normally.
REQ-026 Reset asserted mid-count SHALL abandon the count; no pending load or count SHALL survive reset.

Configuration
REQ-027 Macro MODULO_COUNTER_SATURATE_EN SHALL select boundary behaviour at compile time.
REQ-028 Without MODULO_COUNTER_SATURATE_EN defined, the module SHALL wrap as in REQ-015 and REQ-016.
REQ-029 With MODULO_COUNTER_SATURATE_EN defined, q SHALL hold at MODULUS-1 when counting up and at 0 when counting down, instead of wrapping.
REQ-030 tc SHALL follow REQ-018 in both builds; clear, load and reset SHALL be unaffected by the macro.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-031 The bench SHALL cover reset: reset=0 for 1.5 clock periods with count=1 -> q=0 throughout, and q=1 one edge after release.
REQ-032 The bench SHALL cover up-wrap: q=8, up=1, count=1 for 3 edges -> q=9 (tc=1), 0, 1; tc=1 only while q=9.
REQ-033 The bench SHALL cover down-wrap: q=1, up=0, count=1 for 3 edges -> q=0 (tc=1), 9, 8.
REQ-034 The bench SHALL cover priority and clamping:
- clear=1, load=1, d=5, count=1 -> q=0;
- load=1, d=12 -> q=9;
- load=1, d=5, count=1 -> q=5.
REQ-035 The bench SHALL cover the saturate build (MODULO_COUNTER_SATURATE_EN defined): q=9, up=1, count=1 for 2 edges -> q=9, 9 with tc=1; then up=0 -> q=8.
REQ-036 The bench SHALL cover full range: WIDTH=4, MODULUS=16, 16 up-counts from 0 -> q returns to 0 with a single tc pulse at q=15.
